hack_adder16: RTL and testbench
===============================

// Module: hack_adder16
// PURPOSE
//  16-bit two's-complement adder for the Hack datapath: out = a + b, modulo 2^16.
//  The sum is built from an explicit ripple chain of half/full-adder cells, bit 0 = half adder.
//  The result is captured in an output register with a valid strobe.
//  Feeds the ALU/PC increment paths; a carry-out and signed-overflow flag are provided for debug/status.
// PARAMETERS
//  WIDTH      16   operand/result width in bits; only 16 is supported and verified.
//  RESET_VAL  0    value of out after reset.
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      a/b are valid this cycle; the sum is captured
//  a          in   16     operand A (unsigned or two's complement)
//  b          in   16     operand B
//  out        out  16     registered sum a+b, truncated to 16 bits
//  carry_out  out  1      registered carry from bit 15
//  overflow   out  1      registered signed overflow: (a[15]==b[15]) && (out[15]!=a[15])
//  out_valid  out  1      high for 1 cycle, 1 clock after in_valid
// BEHAVIOUR
//  - Reset (async assert, sync release): out=RESET_VAL, carry_out=0, overflow=0, out_valid=0.
//    Reset mid-operation discards any pending result.
//  - Combinational core:
//    - s[0] = a0^b0; c0 = a0&b0.
//    - For i=1..15: s[i] = a[i]^b[i]^c[i-1]; c[i] = majority(a[i], b[i], c[i-1]).
//    - No carry-in.
//  - Latency 1 cycle. On a rising edge with in_valid=1: out<=s, carry_out<=c15,
//    overflow<=computed flag, out_valid<=1.
//  - On a rising edge with in_valid=0: out/carry_out/overflow hold their values; out_valid<=0.
//  - No backpressure. A new operand pair is accepted every cycle (throughput 1/cycle).
//  - Wrap-around: results >= 2^16 are truncated. The dropped bit appears only on carry_out.
//  - No X propagation requirement beyond standard RTL. Inputs are sampled only on clk edges with in_valid=1.
//  - Purely synchronous datapath apart from rst. No internal state other than the output registers.
// TESTING
//  Drive in_valid=1 per vector, check out/carry_out/overflow/out_valid one cycle later.
//  1. a=0000, b=0000 -> out=0000, carry_out=0, overflow=0, out_valid=1 next cycle.
//  2. a=0000, b=FFFF -> out=FFFF, carry_out=0, overflow=0;
//     a=FFFF, b=FFFF -> out=FFFE, carry_out=1, overflow=0.
//  3. a=AAAA, b=5555 -> out=FFFF, carry_out=0;
//     a=3CC3, b=0FF0 -> out=4CB3, carry_out=0.
//  4. a=1234, b=9876 -> out=AAAA, carry_out=0;
//     a=7FFF, b=0001 -> out=8000, overflow=1, carry_out=0.
//  5. Back-to-back vectors on consecutive cycles:
//     - each result appears exactly 1 cycle later;
//     - in_valid=0 -> out holds, out_valid=0.
//  6. Assert rst asynchronously mid-stream (between clk edges):
//     - out=0000 and out_valid=0 immediately;
//     - after release, the next valid vector is computed correctly.

Source files
------------

// File: rtl/hack_adder16.sv
// Registered 16-bit ripple-carry adder for the Hack datapath.
// Sum, carry-out and signed overflow are captured together with a one-cycle valid strobe.

module hack_adder16_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module hack_adder16_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module hack_adder16 #(
    parameter int unsigned           WIDTH     = 16,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic             ovf;

    // Bit 0 has no carry-in, so it is a half adder; the rest ripple through full adders.
    hack_adder16_ha u_ha0 (
        .a (a[0]),
        .b (b[0]),
        .s (sum[0]),
        .c (carry[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        hack_adder16_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i-1]),
            .s  (sum[i]),
            .co (carry[i])
        );
    end

    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= RESET_VAL;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out       <= sum;
                carry_out <= carry[WIDTH-1];
                overflow  <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_hack_adder16.sv
// Directed-vector bench for hack_adder16: reset, arithmetic corners, back-to-back, hold and async reset.

module tb_hack_adder16;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        carry_out;
    logic        overflow;
    logic        out_valid;

    int vectors;
    int miscompares;

    hack_adder16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, return 1 time unit after the next rising edge.
    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic v);
        @(negedge clk);
        a        = x;
        b        = y;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got out=%h c=%b v=%b ov=%b, want out=0000 c=0 v=0 ov=0",
                     out, carry_out, overflow, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith;
        logic [15:0] va [10];
        logic [15:0] vb [10];
        logic [15:0] eo [10];
        logic        ec [10];
        logic        ev [10];
        va = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
        vb = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876, 16'h0001, 16'h8000, 16'h0001, 16'hFFFE};
        eo = '{16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h4CB3, 16'hAAAA, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF};
        ec = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1};
        ev = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(va[i], vb[i], 1'b1);
            vectors++;
            if ({out, carry_out, overflow, out_valid} !== {eo[i], ec[i], ev[i], 1'b1}) begin
                miscompares++;
                $display("FAIL arith[%0d] %h+%h: got out=%h c=%b ov=%b v=%b, want out=%h c=%b ov=%b v=1",
                         i, va[i], vb[i], out, carry_out, overflow, out_valid, eo[i], ec[i], ev[i]);
            end
            drive(16'h0000, 16'h0000, 1'b0);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL arith_strobe[%0d]: got out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back;
        drive(16'h0001, 16'h0002, 1'b1);
        vectors++;
        if ({out, out_valid} !== {16'h0003, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_0: got out=%h v=%b, want out=0003 v=1", out, out_valid);
        end
        drive(16'h00FF, 16'h0001, 1'b1);
        vectors++;
        if ({out, carry_out, out_valid} !== {16'h0100, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_1: got out=%h c=%b v=%b, want out=0100 c=0 v=1", out, carry_out, out_valid);
        end
        drive(16'hF000, 16'h2000, 1'b1);
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h1000, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_2: got out=%h c=%b ov=%b v=%b, want out=1000 c=1 ov=0 v=1",
                     out, carry_out, overflow, out_valid);
        end
        // Inputs change while in_valid is low: registers must hold the last result.
        drive(16'h1111, 16'h2222, 1'b0);
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h1000, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_0: got out=%h c=%b ov=%b v=%b, want out=1000 c=1 ov=0 v=0",
                     out, carry_out, overflow, out_valid);
        end
        drive(16'h7FFF, 16'h7FFF, 1'b0);
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h1000, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL hold_1: got out=%h c=%b ov=%b v=%b, want out=1000 c=1 ov=0 v=0",
                     out, carry_out, overflow, out_valid);
        end
    endtask

    task automatic test_async_reset;
        drive(16'h4000, 16'h4000, 1'b1);
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h8000, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_rst: got out=%h c=%b ov=%b v=%b, want out=8000 c=0 ov=1 v=1",
                     out, carry_out, overflow, out_valid);
        end
        // Keep a valid vector pending, then reset between edges.
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0002;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_rst: got out=%h c=%b ov=%b v=%b, want out=0000 c=0 ov=0 v=0",
                     out, carry_out, overflow, out_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out, out_valid} !== {16'h0000, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_held: got out=%h v=%b, want out=0000 v=0", out, out_valid);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        drive(16'h0ABC, 16'h1111, 1'b1);
        vectors++;
        if ({out, carry_out, overflow, out_valid} !== {16'h1BCD, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL post_rst: got out=%h c=%b ov=%b v=%b, want out=1BCD c=0 ov=0 v=1",
                     out, carry_out, overflow, out_valid);
        end
        drive(16'h0000, 16'h0000, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
